seq_det_param: RTL

//  Parametrised serial pattern detector; generalises the fixed 5-state "1011" detector.

---
 rtl/seq_det_param.sv | 137 +++++++++++++
 1 files changed

// File: rtl/seq_det_param.sv
`default_nettype none
// ============================================================================
// Module      : seq_det_param
// Description : Parametrised serial pattern detector. While start is high, one
//               bit per clock is shifted into a PAT_LEN-bit window. The window
//               is compared against a runtime-loadable pattern register. A
//               registered one-cycle pulse marks each match. A saturating
//               counter records matches since reset or the last pattern load.
//               Matches may share bits (OVERLAP=1). With OVERLAP=0 the window
//               is flushed after each match.
// Ports       : clock      - rising-edge clock
//               reset      - synchronous, active-high reset
//               start      - bit enable; serial_in is sampled only when high
//               serial_in  - serial data bit
//               pat_load   - one-cycle strobe, loads pat_in as the new pattern
//               pat_in     - new pattern, MSB = first bit received
//               seq_out    - registered one-cycle match pulse
//               match_cnt  - saturating match count
//               cnt_sat    - high while match_cnt is all-ones
//               armed      - high while the window holds PAT_LEN valid bits
// Revision    : 1.0 - initial release
// ============================================================================
module seq_det_param #(
   parameter int unsigned        PAT_LEN = 4,
   parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
   parameter bit                 OVERLAP = 1'b1,
   parameter int unsigned        CNT_W   = 8
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic               serial_in,
   input  logic               pat_load,
   input  logic [PAT_LEN-1:0] pat_in,
   output logic               seq_out,
   output logic [CNT_W-1:0]   match_cnt,
   output logic               cnt_sat,
   output logic               armed
);

   localparam int unsigned FILL_W = $clog2(PAT_LEN + 1);
   localparam logic [FILL_W-1:0] c_full    = FILL_W'(PAT_LEN);
   localparam logic [CNT_W-1:0]  c_cnt_max = {CNT_W{1'b1}};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FILL  = 2'd1,
      ST_ARMED = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [PAT_LEN-1:0]  r_pattern;
   logic [PAT_LEN-1:0]  w_pattern_nxt;
   logic [PAT_LEN-1:0]  r_window;
   logic [PAT_LEN-1:0]  w_window_nxt;
   logic [FILL_W-1:0]   r_fill;
   logic [FILL_W-1:0]   w_fill_nxt;
   logic [CNT_W-1:0]    r_match_cnt;
   logic [CNT_W-1:0]    w_cnt_nxt;
   logic                r_seq_out;
   logic                w_seq_nxt;

   logic                w_bit;
   logic [PAT_LEN-1:0]  w_shift;
   logic [FILL_W-1:0]   w_fill_inc;
   logic                w_hit;

   // Only a definite 1 counts as a one; X or Z enters the window as 0 so an
   // undriven line can never produce a match.
   assign w_bit      = (serial_in === 1'b1);
   assign w_shift    = {r_window[PAT_LEN-2:0], w_bit};
   assign w_fill_inc = (r_fill == c_full) ? c_full : (r_fill + FILL_W'(1));
   // A match requires a fully populated window, so stale zeros left over from
   // reset or a flush can never complete a pattern early.
   assign w_hit      = (w_shift == r_pattern) && (w_fill_inc == c_full);

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_pattern   <= PATTERN;
         r_window    <= '0;
         r_fill      <= '0;
         r_match_cnt <= '0;
         r_seq_out   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_pattern   <= w_pattern_nxt;
         r_window    <= w_window_nxt;
         r_fill      <= w_fill_nxt;
         r_match_cnt <= w_cnt_nxt;
         r_seq_out   <= w_seq_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_pattern_nxt = r_pattern;
      w_window_nxt  = r_window;
      w_fill_nxt    = r_fill;
      w_cnt_nxt     = r_match_cnt;
      w_seq_nxt     = 1'b0;

      if (pat_load) begin
         // A new pattern restarts detection from scratch; the bit presented
         // in this cycle is discarded even if start is high.
         w_pattern_nxt = pat_in;
         w_window_nxt  = '0;
         w_fill_nxt    = '0;
         w_cnt_nxt     = '0;
         w_state_nxt   = ST_IDLE;
      end else if (start) begin
         w_window_nxt = w_shift;
         w_fill_nxt   = w_fill_inc;
         w_state_nxt  = (w_fill_inc == c_full) ? ST_ARMED : ST_FILL;
         if (w_hit) begin
            w_seq_nxt = 1'b1;
            if (r_match_cnt != c_cnt_max) begin
               w_cnt_nxt = r_match_cnt + CNT_W'(1);
            end
            if (OVERLAP == 1'b0) begin
               // Clearing fill alone is enough: the match gate ignores the
               // window contents until PAT_LEN fresh bits have arrived.
               w_fill_nxt  = '0;
               w_state_nxt = ST_FILL;
            end
         end
      end
   end

   assign seq_out   = r_seq_out;
   assign match_cnt = r_match_cnt;
   assign cnt_sat   = (r_match_cnt == c_cnt_max);
   assign armed     = (r_fill == c_full);

endmodule
`default_nettype wire
